// File: rtl/cell_mem_arbiter_pkg.sv
// Shared types for the cell-memory arbiter and its requesters.
package cell_mem_arbiter_pkg;

    // Field width of one cell slot; the arbiter's DATA_W must match it.
    localparam int CELL_DW = 16;

    // Requester ids.
    localparam logic REQ_CORE  = 1'b0;
    localparam logic REQ_ALLOC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        FAULT
    } arb_state_t;

    // One heap cell as seen on the memory port: {header, car, cdr}.
    typedef struct packed {
        logic [CELL_DW-1:0] header;
        logic [CELL_DW-1:0] car;
        logic [CELL_DW-1:0] cdr;
    } cell_t;

endpackage

// File: rtl/cell_mem_arbiter_if.sv
// Requester and memory-port signals of the cell-memory arbiter.
// slave: the arbiter's view; master: the surrounding requesters and memory.
interface cell_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic                  r0_req, r1_req;
    logic                  r0_we, r1_we;
    logic [ADDR_W-1:0]     r0_addr, r1_addr;
    logic [3*DATA_W-1:0]   r0_wdata, r1_wdata;
    logic                  r0_ack, r1_ack;
    logic [DATA_W-1:0]     rd_header, rd_car, rd_cdr;

    logic                  mem_read_enable, mem_write_enable;
    logic [ADDR_W-1:0]     mem_addr;
    logic [3*DATA_W-1:0]   mem_wdata;
    logic                  mem_done;
    logic [DATA_W-1:0]     mem_header, mem_car, mem_cdr;

    logic                  busy, timeout_err;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
               mem_done, mem_header, mem_car, mem_cdr,
        output r0_ack, r1_ack, rd_header, rd_car, rd_cdr,
               mem_read_enable, mem_write_enable, mem_addr, mem_wdata,
               busy, timeout_err
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
               mem_done, mem_header, mem_car, mem_cdr,
        input  r0_ack, r1_ack, rd_header, rd_car, rd_cdr,
               mem_read_enable, mem_write_enable, mem_addr, mem_wdata,
               busy, timeout_err
    );
endinterface

// File: rtl/cell_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);
    // Single requester wins outright; a tie goes to the one that was not granted last.
    assign grant_valid = |req;
    assign grant_id    = (&req) ? ~last_grant : req[1];
endmodule

// File: rtl/cell_mem_arbiter.sv
// Serialises evaluator-core and allocator/GC accesses onto the single cell-memory port.
module cell_mem_arbiter
    import cell_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = CELL_DW,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    cell_mem_arbiter_if.slave bus
);
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, we_q, last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    cell_t             wdata_q, rd_q;
    logic [7:0]        cnt_q;
    logic              timeout_q;
    logic              grant_valid, grant_id, drive;

    rr_pick2 u_pick (
        .req         ({bus.r1_req, bus.r0_req}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; a mem_done on the last allowed WAIT cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_done)            state_d = RESP;
                     else if (cnt_q == LAST_WAIT) state_d = FAULT;
            RESP:    state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's transaction at grant; requesters may not change it until ack anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= REQ_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= REQ_ALLOC;
        end else if (state_q == IDLE && grant_valid) begin
            owner_q      <= grant_id;
            we_q         <= grant_id ? bus.r1_we    : bus.r0_we;
            addr_q       <= grant_id ? bus.r1_addr  : bus.r0_addr;
            wdata_q      <= grant_id ? cell_t'(bus.r1_wdata) : cell_t'(bus.r0_wdata);
            last_grant_q <= grant_id;
        end
    end

    // WAIT-cycle counter; cleared whenever we are not waiting.
    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 8'd1;
    end

    // Read data capture and the sticky fault flag (FAULT only leaves on reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == WAIT && bus.mem_done && !we_q)
                rd_q <= {bus.mem_header, bus.mem_car, bus.mem_cdr};
            timeout_q <= (state_d == FAULT);
        end
    end

    assign drive                = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.mem_read_enable  = (state_q == ISSUE) && !we_q;
    assign bus.mem_write_enable = (state_q == ISSUE) &&  we_q;
    assign bus.mem_addr         = drive ? addr_q  : '0;
    assign bus.mem_wdata        = drive ? wdata_q : '0;
    assign bus.r0_ack           = (state_q == RESP) && (owner_q == REQ_CORE);
    assign bus.r1_ack           = (state_q == RESP) && (owner_q == REQ_ALLOC);
    assign bus.rd_header        = rd_q.header;
    assign bus.rd_car           = rd_q.car;
    assign bus.rd_cdr           = rd_q.cdr;
    assign bus.busy             = (state_q != IDLE);
    assign bus.timeout_err      = timeout_q;
endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Directed bench for cell_mem_arbiter with a small latency-programmable memory model.
`timescale 1ns/1ps
module tb_cell_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cell_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    cell_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    // Memory model: answers mem_lat cycles after the strobe (1 = the cycle right after).
    int          mem_lat = 1;
    bit          mem_en  = 1'b1;
    bit          spur_done = 1'b0;
    logic        md_r = 1'b0;
    logic [47:0] md_data = '0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [7:0]  paddr = '0;
    logic [47:0] wr_store [256];
    bit          wr_valid [256];

    assign bus.mem_done = md_r | spur_done;
    assign {bus.mem_header, bus.mem_car, bus.mem_cdr} = md_data;

    function automatic logic [47:0] dflt(input logic [7:0] a);
        case (a)
            8'h10:   return 48'h0001_002A_0000;
            8'h30:   return 48'h0003_0300_0301;
            8'h40:   return 48'h0004_0400_0401;
            default: return {3{8'h00, a}};
        endcase
    endfunction

    function automatic logic [47:0] lookup(input logic [7:0] a);
        return wr_valid[a] ? wr_store[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        md_r    <= 1'b0;
        md_data <= 48'hDEAD_BEEF_F00D;
        if (rst) begin
            pend <= 1'b0;
        end else if (bus.mem_read_enable || bus.mem_write_enable) begin
            if (bus.mem_write_enable) begin
                wr_store[bus.mem_addr[7:0]] <= bus.mem_wdata;
                wr_valid[bus.mem_addr[7:0]] <= 1'b1;
            end
            paddr <= bus.mem_addr[7:0];
            if (mem_en && mem_lat <= 1) begin
                md_r    <= 1'b1;
                md_data <= bus.mem_write_enable ? 48'hDEAD_BEEF_F00D : lookup(bus.mem_addr[7:0]);
            end else begin
                pend <= 1'b1;
                pcnt <= mem_lat - 1;
            end
        end else if (pend && mem_en) begin
            if (pcnt <= 1) begin
                md_r    <= 1'b1;
                md_data <= lookup(paddr);
                pend    <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        mem_en = 1'b1; mem_lat = 1; spur_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Drives one transaction and waits (bounded) for the owner's ack; at = cycles to ack, -1 if none.
    task automatic run_txn(input bit id, input bit we, input logic [15:0] addr,
                           input logic [47:0] wd, output int at);
        at = -1;
        if (!id) begin bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wd; bus.r0_req = 1'b1; end
        else     begin bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wd; bus.r1_req = 1'b1; end
        for (int c = 1; c <= 400; c++) begin
            tick();
            if ((!id && bus.r0_ack) || (id && bus.r1_ack)) begin at = c; break; end
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_vec++; if ({bus.r0_ack, bus.r1_ack, bus.mem_read_enable, bus.mem_write_enable, bus.busy, bus.timeout_err} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000", {bus.r0_ack, bus.r1_ack, bus.mem_read_enable, bus.mem_write_enable, bus.busy, bus.timeout_err}); end
        n_vec++; if ({bus.rd_header, bus.rd_car, bus.rd_cdr, bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_data: got rd=%h addr=%h wdata=%h want 0", {bus.rd_header, bus.rd_car, bus.rd_cdr}, bus.mem_addr, bus.mem_wdata); end
        rst = 1'b0;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        n_vec++; if (bus.busy !== 1'b0 || bus.r0_ack !== 1'b0 || bus.r1_ack !== 1'b0 || bus.rd_car !== 16'h0) begin
            n_err++; $display("FAIL idle_done_ignored: busy=%b acks=%b%b rd_car=%h want 0 00 0000", bus.busy, bus.r0_ack, bus.r1_ack, bus.rd_car); end
    endtask

    task automatic test_single_read();
        do_reset();
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0010; bus.r0_wdata = '0; bus.r0_req = 1'b1;
        tick();
        n_vec++; if (bus.mem_read_enable !== 1'b1 || bus.mem_write_enable !== 1'b0 || bus.mem_addr !== 16'h0010) begin
            n_err++; $display("FAIL read_strobe_t1: rd=%b wr=%b addr=%h want 1 0 0010", bus.mem_read_enable, bus.mem_write_enable, bus.mem_addr); end
        tick();
        n_vec++; if (bus.mem_read_enable !== 1'b0 || bus.r0_ack !== 1'b0) begin
            n_err++; $display("FAIL read_t2: rd=%b ack=%b want 0 0", bus.mem_read_enable, bus.r0_ack); end
        tick();
        n_vec++; if (bus.r0_ack !== 1'b1 || bus.r1_ack !== 1'b0) begin
            n_err++; $display("FAIL read_ack_t3: r0_ack=%b r1_ack=%b want 1 0", bus.r0_ack, bus.r1_ack); end
        n_vec++; if ({bus.rd_header, bus.rd_car, bus.rd_cdr} !== 48'h0001_002A_0000) begin
            n_err++; $display("FAIL read_data: got %h want 0001002a0000", {bus.rd_header, bus.rd_car, bus.rd_cdr}); end
        bus.r0_req = 1'b0;
        tick();
        n_vec++; if (bus.r0_ack !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL read_after: ack=%b busy=%b want 0 0", bus.r0_ack, bus.busy); end
    endtask

    task automatic test_tie();
        int r0_at, r1_at, r0_n, r1_n, both;
        logic [15:0] car0, car1;
        r0_at = -1; r1_at = -1; r0_n = 0; r1_n = 0; both = 0; car0 = '0; car1 = '0;
        do_reset();
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0030; bus.r0_req = 1'b1;
        bus.r1_we = 1'b0; bus.r1_addr = 16'h0040; bus.r1_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.r0_ack && bus.r1_ack) both++;
            if (bus.r0_ack) begin r0_n++; if (r0_at < 0) r0_at = c; car0 = bus.rd_car; bus.r0_req = 1'b0; end
            if (bus.r1_ack) begin r1_n++; if (r1_at < 0) r1_at = c; car1 = bus.rd_car; bus.r1_req = 1'b0; end
        end
        n_vec++; if (r0_at !== 3 || r1_at !== 7) begin
            n_err++; $display("FAIL tie_order: r0 ack at %0d r1 ack at %0d want 3 and 7", r0_at, r1_at); end
        n_vec++; if (r0_n !== 1 || r1_n !== 1 || both !== 0) begin
            n_err++; $display("FAIL tie_pulses: r0 %0d r1 %0d overlap %0d want 1 1 0", r0_n, r1_n, both); end
        n_vec++; if (car0 !== 16'h0300 || car1 !== 16'h0400) begin
            n_err++; $display("FAIL tie_data: car0=%h car1=%h want 0300 0400", car0, car1); end
    endtask

    task automatic test_back_to_back();
        int n, order [6], at [6];
        logic [15:0] car [6];
        n = 0;
        do_reset();
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0030; bus.r0_req = 1'b1;
        bus.r1_we = 1'b0; bus.r1_addr = 16'h0040; bus.r1_req = 1'b1;
        for (int c = 1; c <= 40 && n < 6; c++) begin
            tick();
            if (bus.r0_ack || bus.r1_ack) begin
                order[n] = bus.r1_ack ? 1 : 0; at[n] = c; car[n] = bus.rd_car; n++;
                if (n == 6) begin bus.r0_req = 1'b0; bus.r1_req = 1'b0; end
            end
        end
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        n_vec++; if (n !== 6) begin
            n_err++; $display("FAIL b2b_count: got %0d acks want 6", n); end
        for (int i = 0; i < n; i++) begin
            n_vec++; if (order[i] !== (i % 2) || car[i] !== ((i % 2) ? 16'h0400 : 16'h0300)) begin
                n_err++; $display("FAIL b2b_grant%0d: owner %0d car %h want owner %0d", i, order[i], car[i], i % 2); end
            n_vec++; if (at[i] !== 3 + 4 * i) begin
                n_err++; $display("FAIL b2b_spacing%0d: ack at %0d want %0d", i, at[i], 3 + 4 * i); end
        end
        tick();
    endtask

    task automatic test_write();
        int at, wp, rp, bad, r0n, ack_at;
        wp = 0; rp = 0; bad = 0; r0n = 0; ack_at = -1;
        do_reset();
        run_txn(1'b0, 1'b0, 16'h0010, '0, at);
        n_vec++; if (at !== 3 || bus.rd_car !== 16'h002A) begin
            n_err++; $display("FAIL write_preread: ack at %0d car %h want 3 002a", at, bus.rd_car); end
        mem_lat = 3;
        bus.r1_we = 1'b1; bus.r1_addr = 16'h0020; bus.r1_wdata = 48'h0002_1234_0000; bus.r1_req = 1'b1;
        for (int c = 1; c <= 20 && ack_at < 0; c++) begin
            tick();
            if (bus.mem_write_enable) wp++;
            if (bus.mem_read_enable)  rp++;
            if (bus.r0_ack) r0n++;
            if (bus.r1_ack) begin ack_at = c; bus.r1_req = 1'b0; end
            else if (bus.mem_addr !== 16'h0020 || bus.mem_wdata !== 48'h0002_1234_0000) bad++;
        end
        n_vec++; if (wp !== 1 || rp !== 0) begin
            n_err++; $display("FAIL write_strobe: wr pulses %0d rd pulses %0d want 1 0", wp, rp); end
        n_vec++; if (bad !== 0) begin
            n_err++; $display("FAIL write_addr_hold: %0d cycles off 0020/0002_1234_0000 want 0", bad); end
        n_vec++; if (ack_at !== 5 || r0n !== 0) begin
            n_err++; $display("FAIL write_ack: r1 ack at %0d r0 acks %0d want 5 0", ack_at, r0n); end
        n_vec++; if ({bus.rd_header, bus.rd_car, bus.rd_cdr} !== 48'h0001_002A_0000) begin
            n_err++; $display("FAIL write_rd_kept: got %h want 0001002a0000", {bus.rd_header, bus.rd_car, bus.rd_cdr}); end
        tick();
        mem_lat = 1;
        run_txn(1'b0, 1'b0, 16'h0020, '0, at);
        n_vec++; if (at !== 3 || {bus.rd_header, bus.rd_car, bus.rd_cdr} !== 48'h0002_1234_0000) begin
            n_err++; $display("FAIL write_readback: ack at %0d data %h want 3 000212340000", at, {bus.rd_header, bus.rd_car, bus.rd_cdr}); end
    endtask

    task automatic test_timeout();
        int acks, strobes;
        acks = 0; strobes = 0;
        do_reset();
        mem_en = 1'b0;
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0010; bus.r0_req = 1'b1;
        tick();
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (bus.r0_ack || bus.r1_ack) acks++;
        end
        n_vec++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL timeout_pre: err=%b busy=%b at WAIT 255 want 0 1", bus.timeout_err, bus.busy); end
        tick();
        n_vec++; if (bus.timeout_err !== 1'b1) begin
            n_err++; $display("FAIL timeout_set: err=%b want 1", bus.timeout_err); end
        bus.r1_we = 1'b0; bus.r1_addr = 16'h0040; bus.r1_req = 1'b1;
        mem_en = 1'b1;
        spur_done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.r0_ack || bus.r1_ack) acks++;
            if (bus.mem_read_enable || bus.mem_write_enable) strobes++;
        end
        spur_done = 1'b0;
        n_vec++; if (acks !== 0 || strobes !== 0 || bus.timeout_err !== 1'b1) begin
            n_err++; $display("FAIL fault_hold: acks %0d strobes %0d err %b want 0 0 1", acks, strobes, bus.timeout_err); end
        rst = 1'b1;
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        tick();
        n_vec++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL fault_clear: err=%b busy=%b want 0 0", bus.timeout_err, bus.busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timeout_edge();
        int at, acks;
        at = -1; acks = 0;
        do_reset();
        mem_lat = 255;
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0030; bus.r0_req = 1'b1;
        tick();
        for (int k = 1; k <= 300 && at < 0; k++) begin
            tick();
            if (bus.r0_ack) begin at = k; bus.r0_req = 1'b0; end
        end
        bus.r0_req = 1'b0;
        n_vec++; if (at !== 256 || bus.timeout_err !== 1'b0 || bus.rd_car !== 16'h0300) begin
            n_err++; $display("FAIL edge_done_wins: ack at %0d err %b car %h want 256 0 0300", at, bus.timeout_err, bus.rd_car); end
        do_reset();
        mem_lat = 256;
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0030; bus.r0_req = 1'b1;
        tick();
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (bus.r0_ack) acks++;
        end
        bus.r0_req = 1'b0;
        n_vec++; if (acks !== 0 || bus.timeout_err !== 1'b1) begin
            n_err++; $display("FAIL edge_late_done: acks %0d err %b want 0 1", acks, bus.timeout_err); end
    endtask

    task automatic test_reset_in_wait();
        int acks, strobes;
        acks = 0; strobes = 0;
        do_reset();
        mem_lat = 5;
        bus.r0_we = 1'b0; bus.r0_addr = 16'h0010; bus.r0_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        bus.r0_req = 1'b0;
        tick();
        n_vec++; if (bus.busy !== 1'b0 || bus.r0_ack !== 1'b0 || bus.mem_read_enable !== 1'b0) begin
            n_err++; $display("FAIL rst_wait: busy=%b ack=%b rd=%b want 0 0 0", bus.busy, bus.r0_ack, bus.mem_read_enable); end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.r0_ack || bus.r1_ack) acks++;
            if (bus.mem_read_enable || bus.mem_write_enable || bus.busy) strobes++;
        end
        n_vec++; if (acks !== 0 || strobes !== 0) begin
            n_err++; $display("FAIL rst_wait_after: acks %0d activity %0d want 0 0", acks, strobes); end
    endtask

    initial begin
        bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r0_we = 1'b0; bus.r1_we = 1'b0;
        bus.r0_addr = '0; bus.r1_addr = '0; bus.r0_wdata = '0; bus.r1_wdata = '0;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_write();
        test_timeout();
        test_timeout_edge();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end
endmodule
